// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, CHECK, DATA, DONE, ERR} state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_W      = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction memory write port and core hold/status lines.
interface imem_loader_if;

    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid marks the
// handshake of the final byte, with the complete word presented alongside.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] low;

    assign word_valid = byte_en && (cnt == 2'(WORD_BYTES - 1));
    // Earlier bytes shift down, so the byte arriving last lands in the top lane.
    assign word       = {byte_in, low};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            low <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            low <= {byte_in, low[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a 16-bit length followed by that many
// little-endian words from a byte stream and writes them to instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input logic          clk,
    input logic          reset_n,
    imem_loader_if.slave bus
);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic             rx_fire;
    logic             start_ok;
    logic             len_bad;
    logic             word_valid;
    logic [31:0]      word;

    assign rx_fire  = bus.rx_valid && bus.rx_ready;
    assign start_ok = bus.start && (state inside {IDLE, DONE, ERR});
    assign len_bad  = (len == '0) || ({1'b0, len} > 17'(DEPTH_WORDS));

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_ok),
        .byte_en    (rx_fire && (state == DATA)),
        .byte_in    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= BASE_ADDR;
            bus.imem_wdata <= '0;
            bus.cpu_hold   <= HOLD_AT_RESET;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            len            <= '0;
            idx            <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            bus.done    <= 1'b0;
            if (word_valid) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= word;
                bus.imem_waddr <= BASE_ADDR + {{(30 - LEN_W){1'b0}}, idx, 2'b00};
                idx            <= idx + LEN_W'(1);
            end
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_ok) begin
                        state        <= LEN0;
                        bus.rx_ready <= 1'b1;
                        bus.cpu_hold <= 1'b1;
                        bus.error    <= 1'b0;
                        idx          <= '0;
                    end else if (state == DONE && bus.imem_we) begin
                        // imem_we is high only in the first DONE cycle, giving a single pulse.
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end
                end
                LEN0: begin
                    if (rx_fire) begin
                        len[7:0] <= bus.rx_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (rx_fire) begin
                        len[15:8]    <= bus.rx_data;
                        state        <= CHECK;
                        bus.rx_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (len_bad) begin
                        state     <= ERR;
                        bus.error <= 1'b1;
                    end else begin
                        state        <= DATA;
                        bus.rx_ready <= 1'b1;
                    end
                end
                DATA: begin
                    if (word_valid && (idx + LEN_W'(1) == len)) begin
                        state        <= DONE;
                        bus.rx_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; two instances (base 0x0 and 0x100)
// receive the same byte stream.
module tb_imem_loader;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] rx_data  = '0;
    logic       rx_valid = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if bus0 ();
    imem_loader_if bus1 ();

    assign bus0.start    = start;
    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.start    = start;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .HOLD_AT_RESET(1'b1)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .HOLD_AT_RESET(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned exp_done   = 0;
    int unsigned done_cnt [2] = '{0, 0};
    logic        prev_we   [2] = '{1'b0, 1'b0};
    logic        prev_done [2] = '{1'b0, 1'b0};
    logic [31:0] exp_addr  [2][$];
    logic [31:0] exp_data  [2][$];
    logic [31:0] img [$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %b required %b", name, act, req);
        end
    endfunction

    // Reference: word i of an image lands at base + 4*i.
    function automatic void expect_write(input int unsigned i, input logic [31:0] w);
        exp_addr[0].push_back(BASE0 + 32'(i) * 32'd4);
        exp_data[0].push_back(w);
        exp_addr[1].push_back(BASE1 + 32'(i) * 32'd4);
        exp_data[1].push_back(w);
    endfunction

    function automatic void mon(input int d, input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic dn);
        if (we) begin
            check1($sformatf("we_not_consecutive%0d", d), prev_we[d], 1'b0);
            if (exp_addr[d].size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write%0d: actual addr %h data %h required no write", d, addr, data);
            end else begin
                check($sformatf("waddr%0d", d), addr, exp_addr[d].pop_front());
                check($sformatf("wdata%0d", d), data, exp_data[d].pop_front());
            end
        end
        if (dn) begin
            done_cnt[d]++;
            check1($sformatf("done_single%0d", d), prev_done[d], 1'b0);
            check($sformatf("done_after_writes%0d", d), 32'(exp_addr[d].size()), 32'd0);
        end
        prev_we[d]   = we;
        prev_done[d] = dn;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_we   = '{1'b0, 1'b0};
            prev_done = '{1'b0, 1'b0};
        end else begin
            mon(0, bus0.imem_we, bus0.imem_waddr, bus0.imem_wdata, bus0.done);
            mon(1, bus1.imem_we, bus1.imem_waddr, bus1.imem_wdata, bus1.done);
        end
    end

    task automatic check_reset();
        check1("rst_rx_ready", bus0.rx_ready, 1'b0);
        check1("rst_imem_we", bus0.imem_we, 1'b0);
        check("rst_waddr0", bus0.imem_waddr, BASE0);
        check("rst_waddr1", bus1.imem_waddr, BASE1);
        check("rst_wdata", bus0.imem_wdata, 32'd0);
        check1("rst_cpu_hold", bus0.cpu_hold, 1'b1);
        check1("rst_done", bus0.done, 1'b0);
        check1("rst_error", bus0.error, 1'b0);
    endtask

    task automatic idle(input int unsigned gap);
        int unsigned n;
        n = (gap == 0) ? 0 : (gap == 1) ? 1 : $urandom_range(0, 3);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!bus0.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.rx_ready) begin
            compared++;
            mismatched++;
            $display("FAIL rx_ready_timeout: actual 0 after %0d cycles required 1", n);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'(w >> (8 * k)));
            idle(gap);
        end
    endtask

    task automatic load(input int unsigned len, input int unsigned gap, input bit start_mid);
        logic [15:0] l16;
        logic [31:0] w;
        int unsigned n;
        bit          bad;
        l16 = 16'(len);
        bad = (len == 0) || (len > DEPTH);
        pulse_start();
        check1("start_clears_error", bus0.error, 1'b0);
        check1("start_holds_cpu", bus0.cpu_hold, 1'b1);
        check1("start_ready", bus0.rx_ready, 1'b1);
        send_byte(l16[7:0]);
        idle(gap);
        send_byte(l16[15:8]);
        if (bad) begin
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            repeat (5) @(negedge clk);
            check1("len_err_error0", bus0.error, 1'b1);
            check1("len_err_error1", bus1.error, 1'b1);
            check1("len_err_hold", bus0.cpu_hold, 1'b1);
            check1("len_err_ready", bus0.rx_ready, 1'b0);
            rx_valid = 1'b0;
            repeat (3) @(negedge clk);
            check1("len_err_sticky", bus0.error, 1'b1);
        end else begin
            for (int unsigned i = 0; i < len; i++) begin
                w = (i < 32'(img.size())) ? img[i] : $urandom();
                expect_write(i, w);
                send_word(w, gap);
                if (start_mid && i == 0) pulse_start();
            end
            exp_done++;
            n = 0;
            while ((done_cnt[0] != exp_done || done_cnt[1] != exp_done) && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("done_count0", done_cnt[0], exp_done);
            check("done_count1", done_cnt[1], exp_done);
            check1("cpu_hold_released", bus0.cpu_hold, 1'b0);
            check1("no_error", bus0.error, 1'b0);
            check1("ready_low_after_done", bus0.rx_ready, 1'b0);
        end
        img.delete();
    endtask

    initial begin : main
        logic [31:0] w0;
        logic [31:0] w1;
        #1 reset_n = 1'b0;
        #1 check_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed image at full rate, then the same image with gaps.
        img = '{32'h0041_82B3, 32'h4074_0333};
        load(2, 0, 1'b0);
        img = '{32'h0041_82B3, 32'h4074_0333};
        load(2, 1, 1'b0);

        load(0, 0, 1'b0);
        load(33, 0, 1'b0);

        load($urandom_range(1, 8), 2, 1'b0);
        load(5, 2, 1'b1);

        // Abort after the 2nd byte of word 1 of a 3-word image.
        w0 = $urandom();
        w1 = $urandom();
        pulse_start();
        send_byte(8'd3);
        send_byte(8'd0);
        expect_write(0, w0);
        send_word(w0, 0);
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        reset_n = 1'b0;
        #1 check_reset();
        check("queue_empty_at_reset", 32'(exp_addr[0].size()), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load(3, 0, 1'b0);

        // Full-depth image; further bytes must be refused.
        load(DEPTH, 0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        repeat (4) @(negedge clk);
        check1("extra_byte_refused", bus0.rx_ready, 1'b0);
        rx_valid = 1'b0;

        for (int r = 0; r < 3; r++) load($urandom_range(1, DEPTH), 2, r[0]);

        repeat (5) @(negedge clk);
        check("pending_writes0", 32'(exp_addr[0].size()), 32'd0);
        check("pending_writes1", 32'(exp_addr[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
